rc4_prga: RTL and testbench
===========================

# rc4_prga

RC4 pseudo-random generation and en/decode stage: the consumer of the permuted S-box that key scheduling produces. Loads the 256-byte state over a write port, then accepts one data byte at a time. Each byte is XORed with the next keystream byte and returned over a valid/ready output handshake. Encryption and decryption are the same operation.

## Interface
- No parameters; byte width 8 and state depth 256 are fixed by RC4.
- clk  in  1  sole clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-low reset
- sbox_wr_en  in  1  write strobe for S-box loading
- sbox_wr_addr  in  8  S-box index to write
- sbox_wr_data  in  8  S-box value to write
- load_done  in  1  one-cycle pulse: the S-box is complete (driven from the key generator's ready flag)
- clear  in  1  synchronous abandon: discard the key and return to EMPTY
- din  in  8  plaintext or ciphertext byte
- din_valid  in  1  din is valid
- din_ready  out  1  block accepts din this cycle
- dout  out  8  din XOR keystream byte
- dout_valid  out  1  dout is valid
- dout_ready  in  1  downstream accepts dout
- key_loaded  out  1  S-box is loaded and the keystream is live
- dbg_j  out  8  current j index, for debug

## Operation
- State registers:
  - S[0..255], 8 bits each.
  - i and j, 8 bits each; all arithmetic is mod 256 (natural 8-bit wrap).
  - din_r, si (8-bit holding registers) and t (8-bit index).
- States and transitions:
  - EMPTY: a write lands when sbox_wr_en=1, giving S[addr] <= data. load_done → IDLE, with i=0 and j=0.
  - IDLE: din_ready=1. On din_valid&&din_ready: din_r <= din, i <= i+1 → FETCH.
  - FETCH: si <= S[i], j <= j+S[i] → SWAP.
  - SWAP: S[i] <= S[j], S[j] <= si, t <= si+S[j], using the pre-swap S[j] → EMIT.
  - EMIT: dout <= din_r ^ S[t], reading post-swap S, and dout_valid <= 1 → HOLD.
  - HOLD: when dout_ready=1, dout_valid <= 0 → IDLE.
- When i==j in SWAP, both writes target one location with the same value; S is unchanged.
- sbox_wr_en is ignored outside EMPTY. load_done is ignored outside EMPTY.
- If sbox_wr_en and load_done occur in the same cycle, the write completes before the transition.
- Writes to an already-written address overwrite it; no completeness check is made.
- clear has priority over every other input, in any state:
  - Next state is EMPTY; i, j, dout_valid and key_loaded go to 0.
  - S is reinitialised to S[m]=m.
  - An in-flight byte is dropped.
- key_loaded=1 in every state except EMPTY. dbg_j mirrors j.
- dout holds its value when dout_valid=0; it is not cleared on handshake.

## Timing
- Reset values:
  - State EMPTY; i=0, j=0, S[m]=m.
  - din_ready=0, dout=0, dout_valid=0, key_loaded=0, dbg_j=0.
- Reset is asynchronous and takes effect mid-operation in any state, with the same values as above.
- Latency: din is accepted at rising edge N, and dout_valid is high after edge N+3 (FETCH N+1, SWAP N+2, EMIT N+3).
- Throughput is one byte per 5 cycles when dout_ready is held high. dout_valid is asserted during HOLD and deasserts the edge after the handshake.
- din_ready is combinational from the state register only (IDLE); it has no dependence on din_valid.
- dout_valid, once high, stays high with dout stable until dout_ready=1, or until clear or reset.
- load_done → IDLE at the next edge; din_ready is high the following cycle.

## Structure
- Shared package rc4_pkg holds:
  - the state encoding (EMPTY/IDLE/FETCH/SWAP/EMIT/HOLD);
  - the mode constants INIT=2'b00, KEY_GENE=2'b01, EN_DE_CODE=2'b10;
  - RC4_N=256.
- One sub-module, rc4_sbox:
  - a 256×8 register array with asynchronous reset to S[m]=m and synchronous clear;
  - two write ports, with port 1 winning on an equal address;
  - three combinational read ports (S[i], S[j], S[t]).
- The FSM, index arithmetic and output register live in rc4_prga.

## Test plan
- Identity S-box: load S[m]=m, then load_done. Send din 0x00 three times. Required dout: 0x02, 0x05, 0x07. dbg_j after each byte: 0x01, 0x03, 0x05.
- Known answer:
  - Load the S-box produced by key scheduling on key "Key" (bench model).
  - Send "Plaintext" 50 6C 61 69 6E 74 65 78 74.
  - Required dout: BB F3 16 E8 D9 40 AF 0A D3.
  - Re-load the same S-box and send that ciphertext; the plaintext must return.
- Backpressure: hold dout_ready=0 for 10 cycles after dout_valid. dout is stable and din_ready=0 throughout. dout_ready=1 → dout_valid drops the next edge and din_ready rises.
- Gating:
  - din_valid=1 in EMPTY: din_ready=0 and no output.
  - sbox_wr_en in IDLE with addr 0x02, data 0xFF: S is unchanged, and the identity case still yields 0x02.
- clear mid-byte: assert clear in SWAP. Required: dout_valid=0, key_loaded=0, state EMPTY. A reload plus load_done restarts at i=j=0, and the first dout for din 0x00 is again 0x02.
- Asynchronous reset: drop rst in HOLD between clock edges. Required: dout_valid=0 and dout=0 immediately, with no clock edge needed; state EMPTY after release.

Source files
------------

// File: rtl/rc4_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// rc4_pkg : shared RC4 constants and PRGA state encoding
// Rev 1.0
// ------------------------------------------------------------------
package rc4_pkg;

   localparam int RC4_N = 256;

   localparam logic [1:0] INIT       = 2'b00;
   localparam logic [1:0] KEY_GENE   = 2'b01;
   localparam logic [1:0] EN_DE_CODE = 2'b10;

   typedef enum logic [2:0] {
      ST_EMPTY = 3'd0,
      ST_IDLE  = 3'd1,
      ST_FETCH = 3'd2,
      ST_SWAP  = 3'd3,
      ST_EMIT  = 3'd4,
      ST_HOLD  = 3'd5
   } prga_state_t;

endpackage : rc4_pkg
`default_nettype wire

// File: rtl/rc4_sbox.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// rc4_sbox : 256x8 state array, two write ports, three read ports
// Rev 1.0
// ------------------------------------------------------------------
module rc4_sbox
   import rc4_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_clear,
   input  logic       i_we1,
   input  logic [7:0] i_waddr1,
   input  logic [7:0] i_wdata1,
   input  logic       i_we2,
   input  logic [7:0] i_waddr2,
   input  logic [7:0] i_wdata2,
   input  logic [7:0] i_raddr_i,
   input  logic [7:0] i_raddr_j,
   input  logic [7:0] i_raddr_t,
   output logic [7:0] o_rdata_i,
   output logic [7:0] o_rdata_j,
   output logic [7:0] o_rdata_t
);

   logic [7:0] r_s [RC4_N];

   // Port 1 is checked first so it wins when both ports hit one entry.
   for (genvar m = 0; m < RC4_N; m++) begin : g_entry
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_s[m] <= 8'(m);
         end else if (i_clear) begin
            r_s[m] <= 8'(m);
         end else if (i_we1 && (i_waddr1 == 8'(m))) begin
            r_s[m] <= i_wdata1;
         end else if (i_we2 && (i_waddr2 == 8'(m))) begin
            r_s[m] <= i_wdata2;
         end
      end
   end

   assign o_rdata_i = r_s[i_raddr_i];
   assign o_rdata_j = r_s[i_raddr_j];
   assign o_rdata_t = r_s[i_raddr_t];

endmodule : rc4_sbox
`default_nettype wire

// File: rtl/rc4_prga.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// rc4_prga : RC4 keystream generation and byte en/decode stage
// Rev 1.0
// ------------------------------------------------------------------
module rc4_prga
   import rc4_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       sbox_wr_en,
   input  logic [7:0] sbox_wr_addr,
   input  logic [7:0] sbox_wr_data,
   input  logic       load_done,
   input  logic       clear,
   input  logic [7:0] din,
   input  logic       din_valid,
   output logic       din_ready,
   output logic [7:0] dout,
   output logic       dout_valid,
   input  logic       dout_ready,
   output logic       key_loaded,
   output logic [7:0] dbg_j
);

   prga_state_t r_state, w_next;

   logic [7:0] r_i, r_j, r_din, r_si, r_t, r_dout;
   logic       r_dout_valid;

   logic       w_we1, w_we2;
   logic [7:0] w_waddr1, w_wdata1, w_waddr2, w_wdata2;
   logic [7:0] w_si, w_sj, w_st;

   rc4_sbox u_sbox (
      .clk       (clk),
      .rst       (rst),
      .i_clear   (clear),
      .i_we1     (w_we1),
      .i_waddr1  (w_waddr1),
      .i_wdata1  (w_wdata1),
      .i_we2     (w_we2),
      .i_waddr2  (w_waddr2),
      .i_wdata2  (w_wdata2),
      .i_raddr_i (r_i),
      .i_raddr_j (r_j),
      .i_raddr_t (r_t),
      .o_rdata_i (w_si),
      .o_rdata_j (w_sj),
      .o_rdata_t (w_st)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_EMPTY;
      else      r_state <= w_next;
   end

   // Port 1 carries S-box loading in EMPTY and the S[j] half of the swap.
   always_comb begin
      w_next   = r_state;
      w_we1    = 1'b0;
      w_waddr1 = sbox_wr_addr;
      w_wdata1 = sbox_wr_data;
      w_we2    = 1'b0;
      w_waddr2 = r_i;
      w_wdata2 = w_sj;
      unique case (r_state)
         ST_EMPTY: begin
            w_we1 = sbox_wr_en;
            if (load_done) w_next = ST_IDLE;
         end
         ST_IDLE:  if (din_valid) w_next = ST_FETCH;
         ST_FETCH: w_next = ST_SWAP;
         ST_SWAP: begin
            w_we1    = 1'b1;
            w_waddr1 = r_j;
            w_wdata1 = r_si;
            w_we2    = 1'b1;
            w_next   = ST_EMIT;
         end
         ST_EMIT:  w_next = ST_HOLD;
         ST_HOLD:  if (dout_ready) w_next = ST_IDLE;
         default:  w_next = ST_EMPTY;
      endcase
      if (clear) w_next = ST_EMPTY;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_i          <= 8'h00;
         r_j          <= 8'h00;
         r_din        <= 8'h00;
         r_si         <= 8'h00;
         r_t          <= 8'h00;
         r_dout       <= 8'h00;
         r_dout_valid <= 1'b0;
      end else if (clear) begin
         r_i          <= 8'h00;
         r_j          <= 8'h00;
         r_dout_valid <= 1'b0;
      end else begin
         unique case (r_state)
            ST_EMPTY: begin
               if (load_done) begin
                  r_i <= 8'h00;
                  r_j <= 8'h00;
               end
            end
            ST_IDLE: begin
               if (din_valid) begin
                  r_din <= din;
                  r_i   <= r_i + 8'd1;
               end
            end
            ST_FETCH: begin
               r_si <= w_si;
               r_j  <= r_j + w_si;
            end
            // w_sj is still the pre-swap S[j] here.
            ST_SWAP: r_t <= r_si + w_sj;
            ST_EMIT: begin
               r_dout       <= r_din ^ w_st;
               r_dout_valid <= 1'b1;
            end
            ST_HOLD: if (dout_ready) r_dout_valid <= 1'b0;
            default: ;
         endcase
      end
   end

   assign din_ready  = (r_state == ST_IDLE);
   assign key_loaded = (r_state != ST_EMPTY);
   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign dbg_j      = r_j;

endmodule : rc4_prga
`default_nettype wire

// File: tb/tb_rc4_prga.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// tb_rc4_prga : scoreboard bench for the RC4 PRGA stage
// Rev 1.0
// ------------------------------------------------------------------
module tb_rc4_prga;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sbox_wr_en = 1'b0;
   logic [7:0] sbox_wr_addr = 8'h00;
   logic [7:0] sbox_wr_data = 8'h00;
   logic       load_done = 1'b0;
   logic       clear = 1'b0;
   logic [7:0] din = 8'h00;
   logic       din_valid = 1'b0;
   logic       din_ready;
   logic [7:0] dout;
   logic       dout_valid;
   logic       dout_ready = 1'b1;
   logic       key_loaded;
   logic [7:0] dbg_j;

   int errors = 0;
   int checks = 0;

   logic [7:0] exp_q [$];
   logic [7:0] sb [256];
   logic [7:0] pt [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
   logic [7:0] ct [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
   logic [7:0] cap;

   rc4_prga dut (
      .clk          (clk),
      .rst          (rst),
      .sbox_wr_en   (sbox_wr_en),
      .sbox_wr_addr (sbox_wr_addr),
      .sbox_wr_data (sbox_wr_data),
      .load_done    (load_done),
      .clear        (clear),
      .din          (din),
      .din_valid    (din_valid),
      .din_ready    (din_ready),
      .dout         (dout),
      .dout_valid   (dout_valid),
      .dout_ready   (dout_ready),
      .key_loaded   (key_loaded),
      .dbg_j        (dbg_j)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // Output monitor: every handshake pops one expected byte.
   always @(negedge clk) begin
      if (rst && dout_valid && dout_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_dout: got %0h required no output", dout);
         end else begin
            chk("dout", {24'h0, dout}, {24'h0, exp_q.pop_front()});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_identity();
      for (int m = 0; m < 256; m++) sb[m] = 8'(m);
   endtask

   task automatic fill_ksa_key();
      logic [7:0] key [3];
      logic [7:0] j;
      logic [7:0] tmp;
      key = '{8'h4B, 8'h65, 8'h79};
      fill_identity();
      j = 8'h00;
      for (int m = 0; m < 256; m++) begin
         j     = 8'(j + sb[m] + key[m % 3]);
         tmp   = sb[m];
         sb[m] = sb[j];
         sb[j] = tmp;
      end
   endtask

   // Last entry is written in the same cycle as load_done.
   task automatic load_sbox();
      for (int m = 0; m < 256; m++) begin
         sbox_wr_en   = 1'b1;
         sbox_wr_addr = 8'(m);
         sbox_wr_data = sb[m];
         load_done    = (m == 255);
         tick();
      end
      sbox_wr_en = 1'b0;
      load_done  = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input logic [7:0] e);
      int n;
      exp_q.push_back(e);
      din       = d;
      din_valid = 1'b1;
      n = 0;
      while (!din_ready && n < 30) begin tick(); n++; end
      chk("accept_in_time", {31'h0, (n < 30)}, 32'h1);
      tick();
      din_valid = 1'b0;
      n = 0;
      while (!din_ready && n < 30) begin tick(); n++; end
      chk("byte_done_in_time", {31'h0, (n < 30)}, 32'h1);
   endtask

   task automatic wait_dout_valid();
      int n;
      n = 0;
      while (!dout_valid && n < 30) begin tick(); n++; end
      chk("dout_valid_in_time", {31'h0, (n < 30)}, 32'h1);
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_din_ready", {31'h0, din_ready}, 32'h0);
      chk("rst_dout", {24'h0, dout}, 32'h0);
      chk("rst_dout_valid", {31'h0, dout_valid}, 32'h0);
      chk("rst_key_loaded", {31'h0, key_loaded}, 32'h0);
      chk("rst_dbg_j", {24'h0, dbg_j}, 32'h0);
      rst = 1'b1;
      tick();

      // din_valid while EMPTY must be ignored.
      din = 8'h55;
      din_valid = 1'b1;
      repeat (4) begin
         tick();
         chk("empty_din_ready", {31'h0, din_ready}, 32'h0);
         chk("empty_key_loaded", {31'h0, key_loaded}, 32'h0);
      end
      din_valid = 1'b0;

      // Identity S-box.
      fill_identity();
      load_sbox();
      chk("loaded_key_loaded", {31'h0, key_loaded}, 32'h1);
      chk("loaded_din_ready", {31'h0, din_ready}, 32'h1);
      send(8'h00, 8'h02); chk("id_j0", {24'h0, dbg_j}, 32'h01);
      send(8'h00, 8'h05); chk("id_j1", {24'h0, dbg_j}, 32'h03);
      send(8'h00, 8'h07); chk("id_j2", {24'h0, dbg_j}, 32'h05);

      // Writes in IDLE are ignored.
      do_clear();
      chk("clear_key_loaded", {31'h0, key_loaded}, 32'h0);
      load_sbox();
      sbox_wr_en = 1'b1; sbox_wr_addr = 8'h02; sbox_wr_data = 8'hFF;
      tick();
      sbox_wr_en = 1'b0;
      send(8'h00, 8'h02);

      // Known answer with key "Key", then decrypt.
      fill_ksa_key();
      do_clear();
      load_sbox();
      for (int k = 0; k < 9; k++) send(pt[k], ct[k]);
      do_clear();
      load_sbox();
      for (int k = 0; k < 9; k++) send(ct[k], pt[k]);

      // Backpressure.
      fill_identity();
      do_clear();
      load_sbox();
      dout_ready = 1'b0;
      din = 8'h00; din_valid = 1'b1;
      exp_q.push_back(8'h02);
      tick();
      din_valid = 1'b0;
      wait_dout_valid();
      cap = dout;
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("bp_dout_stable", {24'h0, dout}, {24'h0, cap});
         chk("bp_dout_valid", {31'h0, dout_valid}, 32'h1);
         chk("bp_din_ready", {31'h0, din_ready}, 32'h0);
      end
      dout_ready = 1'b1;
      tick();
      chk("bp_release_valid", {31'h0, dout_valid}, 32'h0);
      chk("bp_release_ready", {31'h0, din_ready}, 32'h1);

      // clear while in SWAP drops the byte.
      din = 8'h00; din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      tick();
      do_clear();
      chk("clr_dout_valid", {31'h0, dout_valid}, 32'h0);
      chk("clr_key_loaded", {31'h0, key_loaded}, 32'h0);
      chk("clr_din_ready", {31'h0, din_ready}, 32'h0);
      chk("clr_dbg_j", {24'h0, dbg_j}, 32'h0);
      repeat (4) tick();
      load_sbox();
      send(8'h00, 8'h02);
      chk("clr_restart_j", {24'h0, dbg_j}, 32'h01);

      // Asynchronous reset while holding the second byte.
      dout_ready = 1'b0;
      din = 8'h00; din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      wait_dout_valid();
      chk("pre_rst_dout", {24'h0, dout}, 32'h05);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_dout_valid", {31'h0, dout_valid}, 32'h0);
      chk("arst_dout", {24'h0, dout}, 32'h0);
      chk("arst_key_loaded", {31'h0, key_loaded}, 32'h0);
      dout_ready = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      chk("post_rst_din_ready", {31'h0, din_ready}, 32'h0);
      chk("post_rst_key_loaded", {31'h0, key_loaded}, 32'h0);
      chk("post_rst_dbg_j", {24'h0, dbg_j}, 32'h0);
      load_sbox();
      send(8'h00, 8'h02);

      repeat (3) tick();
      chk("queue_empty", exp_q.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_rc4_prga
`default_nettype wire
